wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares one scoreboard writeback port between several multi-cycle functional units (e.g. multiplier, FPU, CVXIF). Each cycle it grants at most one valid requester by round-robin and registers that requester's result onto the writeback port: trans_id, data and exception-valid. It sits between the FU result outputs and one lane of the writeback bus into the scoreboard. It also keeps a saturating contention counter for the performance counters.

## Interface
- NR_REQ, 3: number of requesters; legal range 2..8.
- TRANS_ID_BITS, 3: scoreboard transaction-id width.
- XLEN, 64: result data width.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  pipeline flush; kills the output slot and blocks grants.
- req_valid_i  in  NR_REQ  requester result valid.
- req_ready_o  out  NR_REQ  grant (one-hot or zero); a result transfers when valid&ready.
- req_trans_id_i  in  NR_REQ×TRANS_ID_BITS  per-requester trans id.
- req_data_i  in  NR_REQ×XLEN  per-requester result.
- req_ex_valid_i  in  NR_REQ  per-requester exception flag.
- wb_valid_o  out  1  writeback valid; registered.
- wb_trans_id_o  out  TRANS_ID_BITS  registered trans id.
- wb_data_o  out  XLEN  registered data.
- wb_ex_valid_o  out  1  registered exception flag.
- wb_src_o  out  clog2(NR_REQ)  index of the requester that produced the current wb entry.
- conflict_cnt_o  out  16  saturating count of contention cycles.

## Operation
- The writeback port has no backpressure; the registered output slot drains every cycle.
- Grant, combinational:
  - If flush_i is 1, no grant.
  - Otherwise search from rr_q upward with modulo-NR_REQ wrap. The first index with req_valid_i set gets req_ready_o[g]=1.
  - req_ready_o never depends on wb_valid_o.
- On a grant to g:
  - wb_* are loaded next edge from requester g.
  - wb_src_o<=g.
  - rr_q<=(g+1) mod NR_REQ.
- No grant: wb_valid_o<=0 and rr_q is held. wb_trans_id_o, wb_data_o, wb_ex_valid_o and wb_src_o hold their previous values, which are don't-care while invalid.
- Flush: wb_valid_o<=0 at the next edge, no transfer occurs that cycle, and rr_q is unchanged. A requester that was valid during flush must still be valid afterward to be granted. Dropping the request is the FU's responsibility.
- Contention:
  - Condition: not flush_i and popcount(req_valid_i)>=2.
  - Increment conflict_cnt_o by 1, saturating at 16'hFFFF.
  - Cleared only by reset.
- Requesters must hold valid, trans_id, data and ex_valid stable until granted. The arbiter does not check this.

## Timing
- Latency: a grant in cycle N puts wb_valid_o=1 with that requester's payload in cycle N+1.
- Throughput: one result per cycle.
- Fairness: a continuously valid requester is granted within NR_REQ cycles.
- Reset values: wb_valid_o=0, wb_trans_id_o=0, wb_data_o=0, wb_ex_valid_o=0, wb_src_o=0, rr_q=0, conflict_cnt_o=0.
- req_ready_o is 0 while rst_i is asserted.
- Reset mid-operation: all state clears immediately and asynchronously, and an in-flight wb entry is lost. The first grant after deassertion searches from index 0.
- Pointer wrap: a grant at index NR_REQ-1 sets rr_q=0.
- Simultaneous grant and flush cannot occur, because flush suppresses the grant.
- Counter saturation: at 16'hFFFF it stays there under further contention.

## Test plan
- Reset/idle:
  - Stimulus: assert rst_i mid-cycle with inputs toggling.
  - Required: all outputs 0 asynchronously, req_ready_o=0.
  - After release with no valids, wb_valid_o stays 0.
- Single requester:
  - Stimulus: req 1 valid with trans_id=5, data=64'hDEAD_BEEF, ex=0.
  - Required: req_ready_o=3'b010 in the same cycle. Next cycle wb_valid_o=1, wb_trans_id_o=5, wb_data_o=DEAD_BEEF, wb_src_o=1.
- Round-robin with wrap:
  - Stimulus: all 3 valid continuously from reset, trans_ids 0/1/2.
  - Required: grants 0,1,2,0,1,2; wb_trans_id_o follows 0,1,2,0 one cycle later; conflict_cnt_o increments by 1 each cycle.
- Pointer hold:
  - Stimulus: grant req 2, then idle 3 cycles, then req 0 and req 2 valid together.
  - Required: req 0 granted first, since rr_q wrapped to 0; req 2 granted the next cycle.
- Flush mid-stream:
  - Stimulus: reqs 0 and 1 valid; assert flush_i in the cycle req 1 would win.
  - Required: req_ready_o=0 that cycle, wb_valid_o=0 the next cycle, conflict_cnt_o unchanged. With flush_i low again, req 1 is granted.
- Counter saturation:
  - Stimulus: force contention for 65,540 cycles.
  - Required: conflict_cnt_o reaches 16'hFFFF and stays there.
  - After reset, conflict_cnt_o=0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one registered scoreboard writeback lane between
// several functional units, with a saturating contention counter.
module wb_port_arbiter #(
  parameter int unsigned NR_REQ        = 3,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned XLEN          = 64,
  localparam int unsigned SRC_W        = $clog2(NR_REQ)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  input  logic [NR_REQ-1:0]               req_valid_i,
  output logic [NR_REQ-1:0]               req_ready_o,
  input  logic [NR_REQ*TRANS_ID_BITS-1:0] req_trans_id_i,
  input  logic [NR_REQ*XLEN-1:0]          req_data_i,
  input  logic [NR_REQ-1:0]               req_ex_valid_i,
  output logic                            wb_valid_o,
  output logic [TRANS_ID_BITS-1:0]        wb_trans_id_o,
  output logic [XLEN-1:0]                 wb_data_o,
  output logic                            wb_ex_valid_o,
  output logic [SRC_W-1:0]                wb_src_o,
  output logic [15:0]                     conflict_cnt_o
);

  localparam logic [SRC_W:0]   NR_W     = (SRC_W+1)'(NR_REQ);
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NR_REQ-1);

  logic [SRC_W-1:0]         rr_q;
  logic [SRC_W-1:0]         gnt_idx;
  logic [SRC_W-1:0]         next_rr;
  logic                     gnt_any;
  logic [SRC_W:0]           idx_w;
  logic [SRC_W-1:0]         idx;
  logic [TRANS_ID_BITS-1:0] sel_tid;
  logic [XLEN-1:0]          sel_data;
  logic                     sel_ex;
  logic                     contention;

  // Search starts at rr_q and wraps modulo NR_REQ; reset also masks the grant.
  always_comb begin
    req_ready_o = '0;
    gnt_any     = 1'b0;
    gnt_idx     = '0;
    idx_w       = '0;
    idx         = '0;
    if (!rst_i && !flush_i) begin
      for (int i = 0; i < NR_REQ; i++) begin
        idx_w = {1'b0, rr_q} + (SRC_W+1)'(i);
        if (idx_w >= NR_W) idx_w = idx_w - NR_W;
        idx = idx_w[SRC_W-1:0];
        if (!gnt_any && req_valid_i[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = idx;
        end
      end
      if (gnt_any) req_ready_o[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_tid  = '0;
    sel_data = '0;
    sel_ex   = 1'b0;
    for (int j = 0; j < NR_REQ; j++) begin
      if (req_ready_o[j]) begin
        sel_tid  = req_trans_id_i[j*TRANS_ID_BITS +: TRANS_ID_BITS];
        sel_data = req_data_i[j*XLEN +: XLEN];
        sel_ex   = req_ex_valid_i[j];
      end
    end
  end

  assign next_rr = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;

  // More than one bit set in the valid vector.
  assign contention = !flush_i && (|(req_valid_i & (req_valid_i - NR_REQ'(1))));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q           <= '0;
      wb_valid_o     <= 1'b0;
      wb_trans_id_o  <= '0;
      wb_data_o      <= '0;
      wb_ex_valid_o  <= 1'b0;
      wb_src_o       <= '0;
      conflict_cnt_o <= '0;
    end else begin
      wb_valid_o <= gnt_any;
      if (gnt_any) begin
        wb_trans_id_o <= sel_tid;
        wb_data_o     <= sel_data;
        wb_ex_valid_o <= sel_ex;
        wb_src_o      <= gnt_idx;
        rr_q          <= next_rr;
      end
      if (contention && conflict_cnt_o != 16'hFFFF)
        conflict_cnt_o <= conflict_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with three requesters.
module tb_wb_port_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [2:0]    valid;
  logic [2:0]    ready;
  logic [8:0]    tid_v;
  logic [191:0]  data_v;
  logic [2:0]    ex_v;
  logic          wb_valid;
  logic [2:0]    wb_tid;
  logic [63:0]   wb_data;
  logic          wb_ex;
  logic [1:0]    wb_src;
  logic [15:0]   cnt;
  int            pass_cnt = 0;
  int            total_cnt = 0;

  wb_port_arbiter #(.NR_REQ(3), .TRANS_ID_BITS(3), .XLEN(64)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .req_valid_i    (valid),
    .req_ready_o    (ready),
    .req_trans_id_i (tid_v),
    .req_data_i     (data_v),
    .req_ex_valid_i (ex_v),
    .wb_valid_o     (wb_valid),
    .wb_trans_id_o  (wb_tid),
    .wb_data_o      (wb_data),
    .wb_ex_valid_o  (wb_ex),
    .wb_src_o       (wb_src),
    .conflict_cnt_o (cnt)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic v, input logic [2:0] t,
                         input logic [63:0] d, input logic e);
    valid[i]          = v;
    tid_v[i*3 +: 3]   = t;
    data_v[i*64 +: 64] = d;
    ex_v[i]           = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_req(2, 1'b1, 3'd6, 64'h1234, 1'b1);
    #1;
    total_cnt++; if (ready !== 3'b100) $display("FAIL pre_rst_ready got %b exp %b", ready, 3'b100); else pass_cnt++;
    tick();
    total_cnt++; if (wb_valid !== 1'b1) $display("FAIL pre_rst_wb_valid got %b exp 1", wb_valid); else pass_cnt++;
    total_cnt++; if (wb_tid !== 3'd6) $display("FAIL pre_rst_tid got %0d exp 6", wb_tid); else pass_cnt++;
    total_cnt++; if (wb_ex !== 1'b1) $display("FAIL pre_rst_ex got %b exp 1", wb_ex); else pass_cnt++;
    set_req(0, 1'b1, 3'd3, 64'h55, 1'b0);
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (wb_valid !== 1'b0) $display("FAIL rst_wb_valid got %b exp 0", wb_valid); else pass_cnt++;
    total_cnt++; if (wb_tid !== 3'd0) $display("FAIL rst_tid got %0d exp 0", wb_tid); else pass_cnt++;
    total_cnt++; if (wb_data !== 64'd0) $display("FAIL rst_data got %h exp 0", wb_data); else pass_cnt++;
    total_cnt++; if (wb_ex !== 1'b0) $display("FAIL rst_ex got %b exp 0", wb_ex); else pass_cnt++;
    total_cnt++; if (wb_src !== 2'd0) $display("FAIL rst_src got %0d exp 0", wb_src); else pass_cnt++;
    total_cnt++; if (cnt !== 16'd0) $display("FAIL rst_cnt got %0d exp 0", cnt); else pass_cnt++;
    total_cnt++; if (ready !== 3'b000) $display("FAIL rst_ready got %b exp 000", ready); else pass_cnt++;
    valid = 3'b000;
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    tick();
    total_cnt++; if (wb_valid !== 1'b0) $display("FAIL idle_wb_valid got %b exp 0", wb_valid); else pass_cnt++;
  endtask

  task automatic test_single();
    set_req(1, 1'b1, 3'd5, 64'hDEAD_BEEF, 1'b0);
    #1;
    total_cnt++; if (ready !== 3'b010) $display("FAIL single_ready got %b exp 010", ready); else pass_cnt++;
    tick();
    valid[1] = 1'b0;
    total_cnt++; if (wb_valid !== 1'b1) $display("FAIL single_wb_valid got %b exp 1", wb_valid); else pass_cnt++;
    total_cnt++; if (wb_tid !== 3'd5) $display("FAIL single_tid got %0d exp 5", wb_tid); else pass_cnt++;
    total_cnt++; if (wb_data !== 64'hDEAD_BEEF) $display("FAIL single_data got %h exp deadbeef", wb_data); else pass_cnt++;
    total_cnt++; if (wb_src !== 2'd1) $display("FAIL single_src got %0d exp 1", wb_src); else pass_cnt++;
    total_cnt++; if (wb_ex !== 1'b0) $display("FAIL single_ex got %b exp 0", wb_ex); else pass_cnt++;
    tick();
    total_cnt++; if (wb_valid !== 1'b0) $display("FAIL single_drain got %b exp 0", wb_valid); else pass_cnt++;
  endtask

  task automatic test_rr_wrap();
    logic [2:0] exp_r;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 3'(i), 64'(100 + i), 1'b0);
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_r = 3'b001 << (k % 3);
      total_cnt++; if (ready !== exp_r) $display("FAIL rr_ready[%0d] got %b exp %b", k, ready, exp_r); else pass_cnt++;
      total_cnt++; if (cnt !== 16'(k)) $display("FAIL rr_cnt[%0d] got %0d exp %0d", k, cnt, k); else pass_cnt++;
      tick();
      total_cnt++; if (wb_tid !== 3'(k % 3) || wb_valid !== 1'b1)
        $display("FAIL rr_wb[%0d] got tid %0d valid %b exp tid %0d valid 1", k, wb_tid, wb_valid, k % 3);
      else pass_cnt++;
      total_cnt++; if (wb_data !== 64'(100 + k % 3)) $display("FAIL rr_data[%0d] got %0d exp %0d", k, wb_data, 100 + k % 3); else pass_cnt++;
    end
    valid = 3'b000;
    total_cnt++; if (cnt !== 16'd6) $display("FAIL rr_cnt_end got %0d exp 6", cnt); else pass_cnt++;
  endtask

  task automatic test_pointer_hold();
    set_req(2, 1'b1, 3'd7, 64'hAAAA, 1'b0);
    #1;
    total_cnt++; if (ready !== 3'b100) $display("FAIL hold_first_ready got %b exp 100", ready); else pass_cnt++;
    tick();
    valid = 3'b000;
    total_cnt++; if (wb_src !== 2'd2 || wb_tid !== 3'd7) $display("FAIL hold_first_wb got src %0d tid %0d exp src 2 tid 7", wb_src, wb_tid); else pass_cnt++;
    repeat (3) tick();
    total_cnt++; if (wb_valid !== 1'b0) $display("FAIL hold_idle_valid got %b exp 0", wb_valid); else pass_cnt++;
    set_req(0, 1'b1, 3'd4, 64'hB0, 1'b0);
    set_req(2, 1'b1, 3'd6, 64'hB2, 1'b1);
    #1;
    total_cnt++; if (ready !== 3'b001) $display("FAIL hold_pair_ready got %b exp 001", ready); else pass_cnt++;
    tick();
    valid[0] = 1'b0;
    total_cnt++; if (wb_src !== 2'd0 || wb_tid !== 3'd4) $display("FAIL hold_pair_wb0 got src %0d tid %0d exp src 0 tid 4", wb_src, wb_tid); else pass_cnt++;
    #1;
    total_cnt++; if (ready !== 3'b100) $display("FAIL hold_second_ready got %b exp 100", ready); else pass_cnt++;
    tick();
    valid = 3'b000;
    total_cnt++; if (wb_src !== 2'd2 || wb_tid !== 3'd6 || wb_ex !== 1'b1)
      $display("FAIL hold_pair_wb2 got src %0d tid %0d ex %b exp src 2 tid 6 ex 1", wb_src, wb_tid, wb_ex);
    else pass_cnt++;
    total_cnt++; if (cnt !== 16'd7) $display("FAIL hold_cnt got %0d exp 7", cnt); else pass_cnt++;
  endtask

  task automatic test_flush();
    set_req(0, 1'b1, 3'd1, 64'hF0, 1'b0);
    set_req(1, 1'b1, 3'd2, 64'hF1, 1'b0);
    #1;
    total_cnt++; if (ready !== 3'b001) $display("FAIL flush_pre_ready got %b exp 001", ready); else pass_cnt++;
    tick();
    total_cnt++; if (wb_src !== 2'd0 || cnt !== 16'd8) $display("FAIL flush_pre_wb got src %0d cnt %0d exp src 0 cnt 8", wb_src, cnt); else pass_cnt++;
    flush = 1'b1;
    #1;
    total_cnt++; if (ready !== 3'b000) $display("FAIL flush_ready got %b exp 000", ready); else pass_cnt++;
    tick();
    total_cnt++; if (wb_valid !== 1'b0) $display("FAIL flush_wb_valid got %b exp 0", wb_valid); else pass_cnt++;
    total_cnt++; if (cnt !== 16'd8) $display("FAIL flush_cnt got %0d exp 8", cnt); else pass_cnt++;
    flush = 1'b0;
    #1;
    total_cnt++; if (ready !== 3'b010) $display("FAIL post_flush_ready got %b exp 010", ready); else pass_cnt++;
    tick();
    valid = 3'b000;
    total_cnt++; if (wb_valid !== 1'b1 || wb_src !== 2'd1 || wb_tid !== 3'd2)
      $display("FAIL post_flush_wb got valid %b src %0d tid %0d exp valid 1 src 1 tid 2", wb_valid, wb_src, wb_tid);
    else pass_cnt++;
    total_cnt++; if (cnt !== 16'd9) $display("FAIL post_flush_cnt got %0d exp 9", cnt); else pass_cnt++;
  endtask

  task automatic test_saturation();
    valid = 3'b111;
    repeat (65540) @(posedge clk);
    #1;
    total_cnt++; if (cnt !== 16'hFFFF) $display("FAIL sat_cnt got %h exp ffff", cnt); else pass_cnt++;
    repeat (4) tick();
    total_cnt++; if (cnt !== 16'hFFFF) $display("FAIL sat_hold got %h exp ffff", cnt); else pass_cnt++;
    valid = 3'b000;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (cnt !== 16'd0) $display("FAIL sat_rst got %h exp 0", cnt); else pass_cnt++;
    #1 rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    flush  = 1'b0;
    valid  = '0;
    tid_v  = '0;
    data_v = '0;
    ex_v   = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick();
    test_reset();
    test_single();
    test_rr_wrap();
    test_pointer_hold();
    test_flush();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
